// File: rtl/io_port_pkg.sv
// Shared defaults and interrupt FSM encoding for the host/CPU I/O port bridge.
package io_port_pkg;

    localparam int unsigned DW_DEF    = 8;
    localparam int unsigned DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        INT_IDLE       = 2'd0,
        INT_PULSE      = 2'd1,
        INT_WAIT_DRAIN = 2'd2
    } int_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo
    import io_port_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DW-1:0]              wdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [DW-1:0]              head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage needs no reset; reads are qualified by empty.
    always_ff @(posedge clk) begin
        if (rstn && do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_port_ctrl.sv
// Bridges a host byte stream to a CPU's I_Port/O_Port through two FIFOs,
// with sticky error flags and a one-shot interrupt on input arrival.
module io_port_ctrl
    import io_port_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned DW    = DW_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [DW-1:0]          host_in_data,
    input  logic                   host_in_valid,
    output logic                   host_in_ready,
    output logic [DW-1:0]          host_out_data,
    output logic                   host_out_valid,
    input  logic                   host_out_ready,
    output logic [DW-1:0]          cpu_i_port,
    input  logic                   cpu_in_rd,
    input  logic [DW-1:0]          cpu_o_port,
    input  logic                   cpu_out_wr,
    input  logic                   int_en,
    output logic                   int_sig,
    input  logic                   clr_flags,
    output logic                   in_underflow,
    output logic                   out_overflow,
    output logic [$clog2(DEPTH):0] in_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          in_full;
    logic          in_empty;
    logic [DW-1:0] in_head;
    logic          in_push;

    logic          out_full;
    logic          out_empty;
    logic [CW-1:0] out_count;
    logic [DW-1:0] out_head;
    logic          out_pop;

    logic          underflow_set;
    logic          overflow_set;

    int_state_e    int_state;

    assign in_push       = host_in_valid && !in_full;
    assign out_pop       = host_out_ready && !out_empty;
    assign underflow_set = cpu_in_rd && in_empty;
    assign overflow_set  = cpu_out_wr && out_full && !out_pop;

    assign host_in_ready  = rstn && !in_full;
    assign cpu_i_port     = in_empty ? '0 : in_head;
    assign host_out_valid = (out_count != '0);
    assign host_out_data  = out_empty ? '0 : out_head;

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_in_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (in_push),
        .pop   (cpu_in_rd),
        .wdata (host_in_data),
        .full  (in_full),
        .empty (in_empty),
        .count (in_count),
        .head  (in_head)
    );

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (cpu_out_wr),
        .pop   (out_pop),
        .wdata (cpu_o_port),
        .full  (out_full),
        .empty (out_empty),
        .count (out_count),
        .head  (out_head)
    );

    // Sticky error flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            in_underflow <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            if (underflow_set) begin
                in_underflow <= 1'b1;
            end else if (clr_flags) begin
                in_underflow <= 1'b0;
            end
            if (overflow_set) begin
                out_overflow <= 1'b1;
            end else if (clr_flags) begin
                out_overflow <= 1'b0;
            end
        end
    end

    // One interrupt per empty->non-empty episode; re-armed once the input drains.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            int_state <= INT_IDLE;
            int_sig   <= 1'b0;
        end else begin
            int_sig <= 1'b0;
            if (!int_en) begin
                int_state <= INT_IDLE;
            end else begin
                case (int_state)
                    INT_IDLE: begin
                        if (in_empty && in_push) begin
                            int_state <= INT_PULSE;
                            int_sig   <= 1'b1;
                        end
                    end
                    INT_PULSE: begin
                        int_state <= INT_WAIT_DRAIN;
                    end
                    INT_WAIT_DRAIN: begin
                        if (in_empty) begin
                            int_state <= INT_IDLE;
                        end
                    end
                    default: begin
                        int_state <= INT_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Self-checking bench for io_port_ctrl: directed vector table, hand sequences
// for multi-cycle corners, then random traffic against a queue-based model.
module tb_io_port_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rstn;
    logic [DW-1:0] host_in_data;
    logic          host_in_valid;
    logic          host_in_ready;
    logic [DW-1:0] host_out_data;
    logic          host_out_valid;
    logic          host_out_ready;
    logic [DW-1:0] cpu_i_port;
    logic          cpu_in_rd;
    logic [DW-1:0] cpu_o_port;
    logic          cpu_out_wr;
    logic          int_en;
    logic          int_sig;
    logic          clr_flags;
    logic          in_underflow;
    logic          out_overflow;
    logic [CW-1:0] in_count;

    io_port_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .host_in_data   (host_in_data),
        .host_in_valid  (host_in_valid),
        .host_in_ready  (host_in_ready),
        .host_out_data  (host_out_data),
        .host_out_valid (host_out_valid),
        .host_out_ready (host_out_ready),
        .cpu_i_port     (cpu_i_port),
        .cpu_in_rd      (cpu_in_rd),
        .cpu_o_port     (cpu_o_port),
        .cpu_out_wr     (cpu_out_wr),
        .int_en         (int_en),
        .int_sig        (int_sig),
        .clr_flags      (clr_flags),
        .in_underflow   (in_underflow),
        .out_overflow   (out_overflow),
        .in_count       (in_count)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: plain queues plus interrupt bookkeeping flags.
    logic [7:0] inq[$];
    logic [7:0] outq[$];
    bit m_uf, m_of, m_pulse, m_waiting;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       rd;
        logic       ie;
        logic       clr;
        int         e_cnt;
        logic [7:0] e_ip;
        logic       e_is;
        logic       e_uf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [7:0] d, logic rd, logic ie, logic clr,
                                int e_cnt, logic [7:0] e_ip, logic e_is, logic e_uf);
        vec_t r;
        r.v = v; r.d = d; r.rd = rd; r.ie = ie; r.clr = clr;
        r.e_cnt = e_cnt; r.e_ip = e_ip; r.e_is = e_is; r.e_uf = e_uf;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Apply the rules to whatever inputs the DUT sees at this rising edge.
    function automatic void model_update();
        bit in_empty, in_full, out_full, push_in, pop_in, pop_out, push_out;
        if (!rstn) begin
            inq.delete(); outq.delete();
            m_uf = 0; m_of = 0; m_pulse = 0; m_waiting = 0;
            return;
        end
        in_empty = (inq.size() == 0);
        in_full  = (inq.size() == DEPTH);
        out_full = (outq.size() == DEPTH);
        push_in  = host_in_valid && !in_full;
        pop_in   = cpu_in_rd && !in_empty;
        pop_out  = host_out_ready && (outq.size() != 0);
        push_out = cpu_out_wr && (!out_full || pop_out);

        if (!int_en) begin
            m_pulse = 0; m_waiting = 0;
        end else if (m_pulse) begin
            m_pulse = 0; m_waiting = 1;
        end else if (m_waiting) begin
            if (in_empty) m_waiting = 0;
        end else if (in_empty && push_in) begin
            m_pulse = 1;
        end

        if (cpu_in_rd && in_empty) m_uf = 1;
        else if (clr_flags)        m_uf = 0;
        if (cpu_out_wr && out_full && !pop_out) m_of = 1;
        else if (clr_flags)                     m_of = 0;

        if (pop_in)   void'(inq.pop_front());
        if (push_in)  inq.push_back(host_in_data);
        if (pop_out)  void'(outq.pop_front());
        if (push_out) outq.push_back(cpu_o_port);
    endfunction

    task automatic check_model();
        check("model host_in_ready", 32'(host_in_ready), 32'(rstn && inq.size() < DEPTH));
        check("model in_count", 32'(in_count), 32'(inq.size()));
        check("model cpu_i_port", 32'(cpu_i_port), (inq.size() == 0) ? 32'h0 : 32'(inq[0]));
        check("model host_out_valid", 32'(host_out_valid), 32'(outq.size() != 0));
        if (outq.size() != 0) check("model host_out_data", 32'(host_out_data), 32'(outq[0]));
        check("model int_sig", 32'(int_sig), 32'(m_pulse));
        check("model in_underflow", 32'(in_underflow), 32'(m_uf));
        check("model out_overflow", 32'(out_overflow), 32'(m_of));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_model();
    endtask

    task automatic idle_inputs();
        host_in_valid = 0; host_in_data = '0; host_out_ready = 0;
        cpu_in_rd = 0; cpu_out_wr = 0; cpu_o_port = '0; clr_flags = 0;
    endtask

    initial begin
        rstn = 0; int_en = 0;
        idle_inputs();
        step(); step();
        check("reset host_in_ready", 32'(host_in_ready), 32'h0);
        check("reset cpu_i_port", 32'(cpu_i_port), 32'h0);
        check("reset int_sig", 32'(int_sig), 32'h0);
        rstn = 1;
        step();
        check("release host_in_ready", 32'(host_in_ready), 32'h1);

        // Input path, underflow and interrupt behaviour as a vector table.
        vecs.push_back(mk(1, 8'h05, 0, 0, 0, 1, 8'h05, 0, 0));
        vecs.push_back(mk(1, 8'h03, 0, 0, 0, 2, 8'h05, 0, 0));
        vecs.push_back(mk(1, 8'h07, 0, 0, 0, 3, 8'h05, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 2, 8'h03, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 8'h07, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 8'h2A, 1, 0, 0, 1, 8'h2A, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 8'h11, 0, 1, 0, 1, 8'h11, 1, 0));
        vecs.push_back(mk(1, 8'h22, 0, 1, 0, 2, 8'h11, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 1, 8'h22, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 8'h33, 0, 1, 0, 1, 8'h33, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 8'h44, 0, 0, 0, 1, 8'h44, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 8'h55, 0, 1, 0, 1, 8'h55, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 8'h66, 0, 1, 0, 1, 8'h66, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 0));

        foreach (vecs[i]) begin
            idle_inputs();
            host_in_valid = vecs[i].v; host_in_data = vecs[i].d;
            cpu_in_rd = vecs[i].rd; int_en = vecs[i].ie; clr_flags = vecs[i].clr;
            step();
            check($sformatf("vec%0d in_count", i), 32'(in_count), 32'(vecs[i].e_cnt));
            check($sformatf("vec%0d cpu_i_port", i), 32'(cpu_i_port), 32'(vecs[i].e_ip));
            check($sformatf("vec%0d int_sig", i), 32'(int_sig), 32'(vecs[i].e_is));
            check($sformatf("vec%0d in_underflow", i), 32'(in_underflow), 32'(vecs[i].e_uf));
        end
        idle_inputs(); int_en = 0;

        // Output path: two bytes streamed straight through.
        host_out_ready = 1; cpu_out_wr = 1; cpu_o_port = 8'd8;
        step();
        check("out8 valid", 32'(host_out_valid), 32'h1);
        check("out8 data", 32'(host_out_data), 32'd8);
        cpu_o_port = 8'd5;
        step();
        check("out5 data", 32'(host_out_data), 32'd5);
        cpu_out_wr = 0;
        step();
        check("out drained valid", 32'(host_out_valid), 32'h0);

        // Output overflow, set-beats-clear, and full push with same-cycle pop.
        host_out_ready = 0; cpu_out_wr = 1;
        for (int i = 0; i < 4; i++) begin
            cpu_o_port = 8'hA1 + 8'(i);
            step();
        end
        check("fill no overflow", 32'(out_overflow), 32'h0);
        cpu_o_port = 8'hA5;
        step();
        check("overflow set", 32'(out_overflow), 32'h1);
        check("overflow head intact", 32'(host_out_data), 32'hA1);
        cpu_out_wr = 0; clr_flags = 1;
        step();
        check("overflow cleared", 32'(out_overflow), 32'h0);
        cpu_out_wr = 1; cpu_o_port = 8'hA6;
        step();
        check("overflow set beats clear", 32'(out_overflow), 32'h1);
        cpu_out_wr = 0;
        step();
        check("overflow cleared again", 32'(out_overflow), 32'h0);
        clr_flags = 0; cpu_out_wr = 1; cpu_o_port = 8'hB5; host_out_ready = 1;
        step();
        check("full push+pop no overflow", 32'(out_overflow), 32'h0);
        cpu_out_wr = 0;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] exp_b;
            exp_b = (i < 3) ? 8'hA2 + 8'(i) : 8'hB5;
            check($sformatf("drain byte%0d", i), 32'(host_out_data), 32'(exp_b));
            step();
        end
        check("drained empty", 32'(host_out_valid), 32'h0);

        // Reset mid-operation with strobes active during reset.
        idle_inputs(); int_en = 1;
        for (int i = 0; i < 3; i++) begin
            host_in_valid = 1; host_in_data = 8'hC0 + 8'(i);
            step();
        end
        rstn = 0; cpu_out_wr = 1; cpu_o_port = 8'h77; cpu_in_rd = 1;
        step();
        check("rst in_count", 32'(in_count), 32'h0);
        check("rst cpu_i_port", 32'(cpu_i_port), 32'h0);
        check("rst int_sig", 32'(int_sig), 32'h0);
        check("rst host_in_ready", 32'(host_in_ready), 32'h0);
        check("rst host_out_valid", 32'(host_out_valid), 32'h0);
        check("rst in_underflow", 32'(in_underflow), 32'h0);
        rstn = 1; idle_inputs();
        step();
        check("post-rst host_in_ready", 32'(host_in_ready), 32'h1);
        check("post-rst in_count", 32'(in_count), 32'h0);

        // Random traffic against the model.
        for (int c = 0; c < 2500; c++) begin
            host_in_valid  = ($urandom_range(0, 99) < 50);
            host_in_data   = 8'($urandom);
            cpu_in_rd      = ($urandom_range(0, 99) < 40);
            cpu_out_wr     = ($urandom_range(0, 99) < 45);
            cpu_o_port     = 8'($urandom);
            host_out_ready = ($urandom_range(0, 99) < 45);
            clr_flags      = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) int_en = ~int_en;
            rstn           = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
